// File: rtl/matvec_stream_param.sv
// Streaming K x K signed matrix-vector multiplier: y = M*x over valid/ready streams.
// Define MATVEC_SAT_EN to saturate narrowed results and expose sat_flag.
module matvec_stream_param #(
  parameter int unsigned K     = 8,
  parameter int unsigned IN_W  = 14,
  parameter int unsigned OUT_W = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [IN_W-1:0]  input_data,
  input  logic                    new_matrix,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [OUT_W-1:0] output_data
`ifdef MATVEC_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int unsigned ACC_W = 2 * IN_W + $clog2(K);
  localparam int unsigned PW    = 2 * IN_W;
  localparam int unsigned MW    = $clog2(K * K);
  localparam int unsigned VW    = $clog2(K);
  localparam int unsigned CW    = $clog2(K + 1);

  localparam logic [2:0] StFirst   = 3'd0;
  localparam logic [2:0] StLoadM   = 3'd1;
  localparam logic [2:0] StLoadV   = 3'd2;
  localparam logic [2:0] StCompute = 3'd3;
  localparam logic [2:0] StOutput  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [MW-1:0]            ld_q;    // word index while loading matrix or vector
  logic [CW-1:0]            cnt_q;   // MAC column; reaching K means the row sum is final
  logic [VW-1:0]            row_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  out_q;
  logic                     valid_q;
  logic signed [IN_W-1:0]   mat_q [K*K];
  logic signed [IN_W-1:0]   vec_q [K];

  logic                     accept, out_hs, last_m, last_v, mac_done, last_row;
  logic [VW-1:0]            v_addr;
  logic [MW-1:0]            m_addr;
  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  res;

  assign accept   = input_valid && input_ready;
  assign out_hs   = valid_q && output_ready;
  assign last_m   = ld_q == MW'(K * K - 1);
  assign last_v   = ld_q == MW'(K - 1);
  assign mac_done = cnt_q == CW'(K);
  assign last_row = row_q == VW'(K - 1);

  assign v_addr = cnt_q[VW-1:0];
  assign m_addr = MW'(32'(row_q) * K + 32'(v_addr));
  assign prod   = PW'(mat_q[m_addr]) * PW'(vec_q[v_addr]);

`ifdef MATVEC_SAT_EN
  logic sat, sat_q;
  assign sat_flag = sat_q;
`endif

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign res = OUT_W'(acc_q);
`ifdef MATVEC_SAT_EN
      assign sat = 1'b0;
`endif
    end else begin : g_red
`ifdef MATVEC_SAT_EN
      // In range only when every bit from OUT_W-1 upward matches the sign
      logic hi_same;
      assign hi_same = (&acc_q[ACC_W-1:OUT_W-1]) | ~(|acc_q[ACC_W-1:OUT_W-1]);
      assign sat     = ~hi_same;
      assign res     = hi_same ? acc_q[OUT_W-1:0]
                               : {acc_q[ACC_W-1], {(OUT_W-1){~acc_q[ACC_W-1]}}};
`else
      assign res = acc_q[OUT_W-1:0];
`endif
    end
  endgenerate

  assign input_ready  = !reset &&
                        (state_q == StFirst || state_q == StLoadM || state_q == StLoadV);
  assign output_valid = valid_q;
  assign output_data  = out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFirst:   if (accept) state_d = new_matrix ? StLoadM : StLoadV;
      StLoadM:   if (accept && last_m) state_d = StLoadV;
      StLoadV:   if (accept && last_v) state_d = StCompute;
      StCompute: if (mac_done) state_d = StOutput;
      StOutput:  if (out_hs) state_d = last_row ? StFirst : StCompute;
      default:   state_d = StFirst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFirst;
      ld_q    <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef MATVEC_SAT_EN
      sat_q   <= 1'b0;
`endif
      for (int i = 0; i < K * K; i++) mat_q[i] <= '0;
      for (int i = 0; i < K; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StFirst: begin
          if (accept) begin
            if (new_matrix) mat_q[0] <= input_data;
            else            vec_q[0] <= input_data;
            ld_q <= MW'(1);
          end
        end
        StLoadM: begin
          if (accept) begin
            mat_q[ld_q] <= input_data;
            ld_q        <= last_m ? '0 : ld_q + 1'b1;
          end
        end
        StLoadV: begin
          if (accept) begin
            vec_q[VW'(ld_q)] <= input_data;
            ld_q             <= ld_q + 1'b1;
            cnt_q            <= '0;
            acc_q            <= '0;
            row_q            <= '0;
          end
        end
        StCompute: begin
          if (mac_done) begin
            out_q   <= res;
            valid_q <= 1'b1;
`ifdef MATVEC_SAT_EN
            sat_q   <= sat;
`endif
          end else begin
            acc_q <= acc_q + ACC_W'(prod);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StOutput: begin
          if (out_hs) begin
            valid_q <= 1'b0;
            row_q   <= row_q + 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef MATVEC_SAT_EN
            sat_q   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_stream_param.sv
// Scoreboard bench for matvec_stream_param: a K=8 default instance and a K=2, OUT_W=16 instance.
module tb_matvec_stream_param;

  localparam int OWA = 28;
  localparam int OWB = 16;

  typedef struct {
    longint v;
    bit     s;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                   iv [2];
  logic                   nm [2];
  logic                   ordy [2];
  logic signed [13:0]     id [2];
  logic                   irdy_a, irdy_b, ov_a, ov_b;
  logic signed [OWA-1:0]  od_a;
  logic signed [OWB-1:0]  od_b;
`ifdef MATVEC_SAT_EN
  logic                   sf_a, sf_b;
`endif

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     rnd_rdy = 1'b0;
  exp_t   q_a[$];
  exp_t   q_b[$];
  longint mm [2][64];
  longint sm [64];
  longint sv [8];

  matvec_stream_param #(.K(8), .IN_W(14), .OUT_W(OWA)) u_dut_a (
`ifdef MATVEC_SAT_EN
    .sat_flag     (sf_a),
`endif
    .clk          (clk),
    .reset        (reset),
    .input_valid  (iv[0]),
    .input_ready  (irdy_a),
    .input_data   (id[0]),
    .new_matrix   (nm[0]),
    .output_valid (ov_a),
    .output_ready (ordy[0]),
    .output_data  (od_a)
  );

  matvec_stream_param #(.K(2), .IN_W(14), .OUT_W(OWB)) u_dut_b (
`ifdef MATVEC_SAT_EN
    .sat_flag     (sf_b),
`endif
    .clk          (clk),
    .reset        (reset),
    .input_valid  (iv[1]),
    .input_ready  (irdy_b),
    .input_data   (id[1]),
    .new_matrix   (nm[1]),
    .output_valid (ov_b),
    .output_ready (ordy[1]),
    .output_data  (od_b)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 1) ? irdy_b : irdy_a;
  endfunction

  function automatic longint reduce(input longint acc, input int w, output bit sat);
    longint lim;
    longint m;
    lim = longint'(1) <<< (w - 1);
    sat = 1'b0;
`ifdef MATVEC_SAT_EN
    m = acc;
    if (acc >= lim) begin sat = 1'b1; m = lim - 1; end
    if (acc < -lim) begin sat = 1'b1; m = -lim; end
`else
    m = acc & ((lim <<< 1) - 1);
    if (m >= lim) m = m - (lim <<< 1);
`endif
    return m;
  endfunction

  // Output monitor: a result is consumed at the edge following a negedge with valid&&ready
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ov_a && ordy[0]) begin
        if (q_a.size() == 0) check("a_stray_output", ov_a, 0);
        else begin
          e = q_a.pop_front();
          check("a_y", od_a, e.v);
`ifdef MATVEC_SAT_EN
          check("a_sat_flag", sf_a, e.s);
`endif
        end
      end
      if (ov_b && ordy[1]) begin
        if (q_b.size() == 0) check("b_stray_output", ov_b, 0);
        else begin
          e = q_b.pop_front();
          check("b_y", od_b, e.v);
`ifdef MATVEC_SAT_EN
          check("b_sat_flag", sf_b, e.s);
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) ordy[0] = 1'($urandom_range(0, 1));
  end

  // All tasks start and return at 1 time unit after a rising edge
  task automatic send(input int s, input longint d, input bit nmv, input bit gaps);
    bit r;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    iv[s] = 1'b1;
    id[s] = d[13:0];
    nm[s] = nmv;
    n = 0;
    do begin
      @(negedge clk);
      r = rdy(s);
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 2000);
    if (!r) check("accept_timeout", r, 1);
    iv[s] = 1'b0;
    id[s] = 14'($urandom);
    nm[s] = 1'($urandom);
  endtask

  task automatic push(input int s, input longint v, input bit sf);
    exp_t e;
    e.v = v;
    e.s = sf;
    if (s == 1) q_b.push_back(e);
    else        q_a.push_back(e);
  endtask

  task automatic product(input int s, input bit newm, input bit autoexp, input bit gaps);
    int     kk;
    longint acc;
    exp_t   e;
    kk = (s == 1) ? 2 : 8;
    if (newm) begin
      for (int i = 0; i < kk * kk; i++) begin
        mm[s][i] = sm[i];
        send(s, sm[i], (i == 0) ? 1'b1 : 1'($urandom), gaps);
      end
    end
    if (autoexp) begin
      for (int r = 0; r < kk; r++) begin
        acc = 0;
        for (int c = 0; c < kk; c++) acc += mm[s][r * kk + c] * sv[c];
        e.v = reduce(acc, (s == 1) ? OWB : OWA, e.s);
        push(s, e.v, e.s);
      end
    end
    for (int i = 0; i < kk; i++)
      send(s, sv[i], (i == 0) ? newm & 1'b0 : 1'($urandom), gaps);
  endtask

  task automatic drain(input int s);
    int    n;
    string tag;
    n = 0;
    while (((s == 1) ? q_b.size() : q_a.size()) != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tag = (s == 1) ? "b_drain" : "a_drain";
    check(tag, (s == 1) ? q_b.size() : q_a.size(), 0);
  endtask

  function automatic longint rnd14();
    return longint'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    int     n;
    bit     newm;
    longint held;

    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; nm[s] = 1'b0; id[s] = '0; ordy[s] = 1'b1;
      for (int i = 0; i < 64; i++) mm[s][i] = 0;
    end
    #800_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int     n;
    bit     newm;
    longint held;

    #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_ready", irdy_a, 0);
    check("a_reset_valid", ov_a, 0);
    check("a_reset_data", od_a, 0);
    check("b_reset_ready", irdy_b, 0);
    check("b_reset_valid", ov_b, 0);
    check("b_reset_data", od_b, 0);
`ifdef MATVEC_SAT_EN
    check("a_reset_sat", sf_a, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("a_ready_after_reset", irdy_a, 1);
    check("b_ready_after_reset", irdy_b, 1);
    @(posedge clk);
    #1;

    // Cold start: zero matrix
    sv[0] = 7; sv[1] = 9;
    push(1, 0, 0); push(1, 0, 0);
    product(1, 0, 0, 0);
    drain(1);

    // Load [1 2; 3 4], x = [5 6]; also first-result latency
    sm[0] = 1; sm[1] = 2; sm[2] = 3; sm[3] = 4;
    sv[0] = 5; sv[1] = 6;
    push(1, 17, 0); push(1, 39, 0);
    product(1, 1, 0, 0);
    @(negedge clk);
    check("b_ready_in_compute", irdy_b, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ov_b && n < 20);
    check("b_first_valid_latency", n, 3);
    drain(1);
    @(negedge clk);
    check("b_ready_after_last", irdy_b, 1);
    @(posedge clk);
    #1;

    // Reuse matrix with x = [1 -1]
    sv[0] = 1; sv[1] = -1;
    push(1, -1, 0); push(1, -1, 0);
    product(1, 0, 0, 0);
    drain(1);

    // Overflow on the narrow instance
    sm[0] = 8191; sm[1] = 8191; sm[2] = 1; sm[3] = -1;
    sv[0] = 8191; sv[1] = 8191;
`ifdef MATVEC_SAT_EN
    push(1, 32767, 1);
`else
    push(1, -32766, 0);
`endif
    push(1, 0, 0);
    product(1, 1, 0, 0);
    drain(1);

    // Backpressure on the K=8 instance
    for (int i = 0; i < 64; i++) sm[i] = rnd14();
    for (int i = 0; i < 8; i++) sv[i] = rnd14();
    ordy[0] = 1'b0;
    product(0, 1, 1, 0);
    n = 0;
    while (!ov_a && n < 50) begin @(posedge clk); #1; n++; end
    check("a_bp_valid_seen", ov_a, 1);
    held = od_a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("a_bp_data_stable", od_a, held);
      check("a_bp_valid_held", ov_a, 1);
      check("a_bp_ready_low", irdy_a, 0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    drain(0);

    // Random traffic with a reset in the middle of product 50
    rnd_rdy = 1'b1;
    for (int p = 1; p <= 100; p++) begin
      newm = (p != 51) && ($urandom_range(0, 2) == 0);
      if (newm) for (int i = 0; i < 64; i++) sm[i] = rnd14();
      for (int i = 0; i < 8; i++) sv[i] = rnd14();
      product(0, newm, 1, 1);
      if (p == 50) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        q_a.delete();
        q_b.delete();
        for (int s = 0; s < 2; s++) for (int i = 0; i < 64; i++) mm[s][i] = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("a_midreset_valid", ov_a, 0);
        check("a_midreset_ready", irdy_a, 0);
        check("a_midreset_data", od_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end
    drain(0);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("a_idle_no_valid", ov_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
